// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: consumer-side bundle of the PS/2 receiver.
// The receiver drives the master modport, the consumer the slave modport.
//
// Handshake: valid_o is high whenever the FIFO holds at least one entry, and
// data_o/break_o/ext_o then describe the head entry.  An entry is consumed on
// every rising clock edge where valid_o && ready_i.  ready_i with valid_o low
// is ignored.  valid_o never drops without a pop, and the head entry never
// changes without a pop.
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                              valid_o;
    logic                              ready_i;
    logic [7:0]                        data_o;
    logic                              break_o;
    logic                              ext_o;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o;
    logic                              parity_err_o;
    logic                              frame_err_o;
    logic                              overflow_o;

    modport master (
        output valid_o, data_o, break_o, ext_o, count_o,
               parity_err_o, frame_err_o, overflow_o,
        input  ready_i
    );

    modport slave (
        input  valid_o, data_o, break_o, ext_o, count_o,
               parity_err_o, frame_err_o, overflow_o,
        output ready_i
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a show-ahead receive FIFO.
// Both PS/2 lines are synchronised, the clock is debounced by a run-length
// filter, frames (start, 8 data LSB first, odd parity, stop) are checked and
// good bytes are pushed into the FIFO.
//
// Optional feature macro: PS2_RX_BREAK_DECODE_EN
//   defined   : 0xE0 / 0xF0 prefix bytes are absorbed into pending ext/break
//               flags that travel with the next pushed byte.
//   undefined : every accepted byte is pushed raw; break_o/ext_o are 0.
//
// dbg_state_o exposes the frame FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP).
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk_50_i,
    input  logic              rst_n_i,
    input  logic              ps2_clk_i,
    input  logic              ps2_dat_i,
    ps2_rx_fifo_if.master     rx,
    output logic [1:0]        dbg_state_o
);

    localparam int FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
`ifdef PS2_RX_BREAK_DECODE_EN
    localparam int EW  = 10;
`else
    localparam int EW  = 8;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // synchronisers and clock filter
    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           filt_clk;
    logic [FCW-1:0] filt_cnt;
    logic           fall_evt;

    // frame FSM
    state_t         state;
    logic [7:0]     shift;
    logic [2:0]     bit_cnt;
    logic           par_bit;
    logic [TOW-1:0] to_cnt;
    logic           parity_err, frame_err, overflow;
`ifdef PS2_RX_BREAK_DECODE_EN
    logic           ext_pend, brk_pend;
`endif

    // FIFO
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [EW-1:0]  head;
    logic [EW-1:0]  push_entry;

    // decode helpers
    logic           stop_evt, par_ok, frame_good, is_prefix;
    logic           push_req, push_ok, push_ovf, pop, full, valid;

    // Two-flop synchronisers; idle PS/2 lines are high so reset to 1.
    always_ff @(posedge clk_50_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_i;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat_i;
            dat_s2 <= dat_s1;
        end
    end

    // Clock filter: flip only after FILTER_LEN consecutive differing samples;
    // a 1->0 flip raises a one-cycle falling-edge event.
    always_ff @(posedge clk_50_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall_evt <= 1'b0;
        end else begin
            fall_evt <= 1'b0;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
                fall_evt <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + FCW'(1);
            end
        end
    end

    // Frame checks and FIFO push/pop decisions for the current cycle.
    always_comb begin
        stop_evt   = (state == S_STOP) && fall_evt;
        par_ok     = ^{shift, par_bit};          // odd parity: total ones odd
        frame_good = stop_evt && par_ok && dat_s2;
        is_prefix  = 1'b0;
`ifdef PS2_RX_BREAK_DECODE_EN
        is_prefix  = (shift == 8'hE0) || (shift == 8'hF0);
        push_entry = {brk_pend, ext_pend, shift};
`else
        push_entry = shift;
`endif
        push_req   = frame_good && !is_prefix;
        valid      = (count != '0);
        full       = (count == CW'(FIFO_DEPTH));
        pop        = valid && rx.ready_i;
        push_ok    = push_req && (!full || pop);
        push_ovf   = push_req && full && !pop;
    end

    // Frame FSM with timeout; error pulses and prefix flags are registered here.
    always_ff @(posedge clk_50_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            shift      <= 8'h00;
            bit_cnt    <= 3'd0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
`ifdef PS2_RX_BREAK_DECODE_EN
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
`endif
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            if (state != S_IDLE && !fall_evt && to_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
                // line stalled mid-frame: abandon it
                state     <= S_IDLE;
                to_cnt    <= '0;
                frame_err <= 1'b1;
`ifdef PS2_RX_BREAK_DECODE_EN
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
`endif
            end else begin
                if (state == S_IDLE || fall_evt)
                    to_cnt <= '0;
                else
                    to_cnt <= to_cnt + TOW'(1);
                case (state)
                    S_IDLE: begin
                        if (fall_evt && !dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        if (fall_evt) begin
                            shift   <= {dat_s2, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        if (fall_evt) begin
                            par_bit <= dat_s2;
                            state   <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (fall_evt) begin
                            state <= S_IDLE;
                            if (!par_ok)
                                parity_err <= 1'b1;
                            else if (!dat_s2)
                                frame_err <= 1'b1;
                            else if (push_ovf)
                                overflow <= 1'b1;
`ifdef PS2_RX_BREAK_DECODE_EN
                            // prefixes arm flags; any other outcome consumes or drops them
                            if (frame_good && shift == 8'hE0) begin
                                ext_pend <= 1'b1;
                            end else if (frame_good && shift == 8'hF0) begin
                                brk_pend <= 1'b1;
                            end else begin
                                ext_pend <= 1'b0;
                                brk_pend <= 1'b0;
                            end
`endif
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // FIFO storage; contents need no reset because valid gates the outputs.
    always_ff @(posedge clk_50_i) begin
        if (push_ok)
            mem[wr_ptr] <= push_entry;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk_50_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head            = mem[rd_ptr];
    assign rx.valid_o      = valid;
    assign rx.data_o       = valid ? head[7:0] : 8'h00;
`ifdef PS2_RX_BREAK_DECODE_EN
    assign rx.ext_o        = valid ? head[8] : 1'b0;
    assign rx.break_o      = valid ? head[9] : 1'b0;
`else
    assign rx.ext_o        = 1'b0;
    assign rx.break_o      = 1'b0;
`endif
    assign rx.count_o      = count;
    assign rx.parity_err_o = parity_err;
    assign rx.frame_err_o  = frame_err;
    assign rx.overflow_o   = overflow;
    assign dbg_state_o     = state;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed bench for ps2_rx_fifo with hand-computed expectations.
module tb_ps2_rx_fifo;
    localparam int FL    = 8;
    localparam int DEPTH = 16;
    localparam int TO    = 1000;
    localparam int HALF  = 20;

    logic       clk_50_i  = 1'b0;
    logic       rst_n_i   = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_dat_i = 1'b1;
    logic [1:0] dbg_state;

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rx_if ();

    ps2_rx_fifo #(
        .FILTER_LEN     (FL),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_50_i    (clk_50_i),
        .rst_n_i     (rst_n_i),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_dat_i   (ps2_dat_i),
        .rx          (rx_if.master),
        .dbg_state_o (dbg_state)
    );

    // clock
    always #10 clk_50_i = ~clk_50_i;

    int tests = 0;
    int fails = 0;
    int par_n = 0;
    int frm_n = 0;
    int ovf_n = 0;
    int p0, f0, o0;

    // pulse counters, sampled mid-cycle
    always @(negedge clk_50_i) begin
        if (rx_if.parity_err_o) par_n++;
        if (rx_if.frame_err_o)  frm_n++;
        if (rx_if.overflow_o)   ovf_n++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_dat_i = b;
        tick(HALF);
        ps2_clk_i = 1'b0;
        tick(HALF);
        ps2_clk_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_inv, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d) ^ par_inv);
        send_bit(stop);
        ps2_dat_i = 1'b1;
    endtask

    // good frame whose push lands in the same cycle as a pop
    task automatic send_frame_pop(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d));
        ps2_dat_i = 1'b1;
        tick(HALF);
        ps2_clk_i = 1'b0;
        tick(FL + 2);
        rx_if.ready_i = 1'b1;
        tick(1);
        rx_if.ready_i = 1'b0;
        tick(HALF - FL - 3);
        ps2_clk_i = 1'b1;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(rx_if.valid_o), 32'd1);
        check({tag, "_data"}, 32'(rx_if.data_o), 32'(exp));
        rx_if.ready_i = 1'b1;
        tick(1);
        rx_if.ready_i = 1'b0;
    endtask

    initial begin
        rx_if.ready_i = 1'b0;

        // reset state
        tick(3);
        check("rst_valid", 32'(rx_if.valid_o), 32'd0);
        check("rst_data", 32'(rx_if.data_o), 32'h00);
        check("rst_count", 32'(rx_if.count_o), 32'd0);
        check("rst_break", 32'(rx_if.break_o), 32'd0);
        check("rst_ext", 32'(rx_if.ext_o), 32'd0);
        check("rst_perr", 32'(rx_if.parity_err_o), 32'd0);
        check("rst_ferr", 32'(rx_if.frame_err_o), 32'd0);
        check("rst_ovf", 32'(rx_if.overflow_o), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n_i = 1'b1;
        tick(5);

        // glitch of FILTER_LEN-1 cycles with data low: must not start a frame
        ps2_dat_i = 1'b0;
        ps2_clk_i = 1'b0;
        tick(FL - 1);
        ps2_clk_i = 1'b1;
        tick(30);
        ps2_dat_i = 1'b1;
        check("glitch_state", 32'(dbg_state), 32'd0);
        check("glitch_count", 32'(rx_if.count_o), 32'd0);
        tick(HALF);

        // 0x1C with exact push latency: event FL+2 cycles after line falls, entry one later
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h1C >> i));
        send_bit(1'b0);                      // 0x1C has three ones -> parity 0
        ps2_dat_i = 1'b1;
        tick(HALF);
        ps2_clk_i = 1'b0;
        tick(FL + 2);
        check("lat_valid_early", 32'(rx_if.valid_o), 32'd0);
        tick(1);
        check("lat_valid", 32'(rx_if.valid_o), 32'd1);
        check("lat_data", 32'(rx_if.data_o), 32'h1C);
        check("lat_count", 32'(rx_if.count_o), 32'd1);
        tick(HALF - FL - 3);
        ps2_clk_i = 1'b1;
        tick(HALF);
        check("hold_count", 32'(rx_if.count_o), 32'd1);
        pop_expect("pop1c", 8'h1C);
        check("pop1c_count", 32'(rx_if.count_o), 32'd0);
        check("pop1c_valid", 32'(rx_if.valid_o), 32'd0);
        // ready with empty FIFO does nothing
        rx_if.ready_i = 1'b1;
        tick(3);
        rx_if.ready_i = 1'b0;
        check("empty_ready_count", 32'(rx_if.count_o), 32'd0);

        // parity error
        p0 = par_n; f0 = frm_n;
        send_frame(8'h1C, 1'b1, 1'b1);
        tick(HALF);
        check("perr_pulses", 32'(par_n - p0), 32'd1);
        check("perr_no_ferr", 32'(frm_n - f0), 32'd0);
        check("perr_count", 32'(rx_if.count_o), 32'd0);

        // bad stop bit
        p0 = par_n; f0 = frm_n;
        send_frame(8'h1C, 1'b0, 1'b0);
        tick(HALF);
        check("stop_ferr", 32'(frm_n - f0), 32'd1);
        check("stop_no_perr", 32'(par_n - p0), 32'd0);
        check("stop_count", 32'(rx_if.count_o), 32'd0);

        // both bad: parity wins
        p0 = par_n; f0 = frm_n;
        send_frame(8'h3A, 1'b1, 1'b0);
        tick(HALF);
        check("both_perr", 32'(par_n - p0), 32'd1);
        check("both_no_ferr", 32'(frm_n - f0), 32'd0);
        check("state_after_err", 32'(dbg_state), 32'd0);

        // fill, overflow on 17th, then push+pop while full
        o0 = ovf_n;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b1);
        tick(HALF);
        check("full_count", 32'(rx_if.count_o), 32'd16);
        check("ovf_pulses", 32'(ovf_n - o0), 32'd1);
        check("full_head", 32'(rx_if.data_o), 32'h01);
        o0 = ovf_n;
        send_frame_pop(8'h12);
        tick(HALF);
        check("simul_count", 32'(rx_if.count_o), 32'd16);
        check("simul_no_ovf", 32'(ovf_n - o0), 32'd0);
        for (int i = 2; i <= DEPTH; i++) pop_expect("fifo_order", 8'(i));
        pop_expect("fifo_last", 8'h12);
        check("drain_count", 32'(rx_if.count_o), 32'd0);

        // timeout mid-frame, then recovery
        f0 = frm_n;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_dat_i = 1'b1;
        tick(2);
        check("to_in_data", 32'(dbg_state), 32'd1);
        tick(TO + 100);
        check("to_ferr", 32'(frm_n - f0), 32'd1);
        check("to_state", 32'(dbg_state), 32'd0);
        check("to_count", 32'(rx_if.count_o), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1);
        tick(HALF);
        check("to_next_count", 32'(rx_if.count_o), 32'd1);
        pop_expect("to_next", 8'h5A);

        // prefix bytes
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        tick(HALF);
`ifdef PS2_RX_BREAK_DECODE_EN
        check("brk_count", 32'(rx_if.count_o), 32'd1);
        check("brk_ext", 32'(rx_if.ext_o), 32'd1);
        check("brk_break", 32'(rx_if.break_o), 32'd1);
        pop_expect("brk_data", 8'h75);
`else
        check("raw_count", 32'(rx_if.count_o), 32'd3);
        check("raw_ext", 32'(rx_if.ext_o), 32'd0);
        check("raw_break", 32'(rx_if.break_o), 32'd0);
        pop_expect("raw_e0", 8'hE0);
        pop_expect("raw_f0", 8'hF0);
        pop_expect("raw_75", 8'h75);
`endif
        check("prefix_drained", 32'(rx_if.count_o), 32'd0);

        // reset mid-frame with a stored entry
        send_frame(8'h21, 1'b0, 1'b1);
        tick(HALF);
        check("pre_rst_count", 32'(rx_if.count_o), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_dat_i = 1'b1;
        rst_n_i = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rx_if.valid_o), 32'd0);
        check("mid_rst_data", 32'(rx_if.data_o), 32'h00);
        check("mid_rst_count", 32'(rx_if.count_o), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        check("mid_rst_ferr", 32'(rx_if.frame_err_o), 32'd0);
        tick(3);
        rst_n_i = 1'b1;
        tick(HALF);
        send_frame(8'h33, 1'b0, 1'b1);
        tick(HALF);
        check("post_rst_count", 32'(rx_if.count_o), 32'd1);
        pop_expect("post_rst", 8'h33);
        check("post_rst_empty", 32'(rx_if.count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
